// File: rtl/rob_tid_alloc_pkg.sv
// Shared widths, tID type and output-stage state encodings for the ROB tID allocator.
package rob_tid_alloc_pkg;

   localparam int TID_WIDTH      = 4;
   localparam int FIFO_SIZE      = 8;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;

   typedef logic [TID_WIDTH-1:0] tid_t;

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

endpackage

// File: rtl/rob_tid_alloc_tid_table.sv
// tID -> ARID map: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after it is issued; read is same-cycle.
// Backpressure: none; the caller guarantees write and read indices never collide.
module rob_tid_alloc_tid_table #(
   parameter int TID_WIDTH = 4,
   parameter int ID_WIDTH  = 4
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [TID_WIDTH-1:0] wr_idx,
   input  logic [ID_WIDTH-1:0]  wr_dat,
   input  logic [TID_WIDTH-1:0] rd_idx,
   output logic [ID_WIDTH-1:0]  rd_dat
);

   logic [ID_WIDTH-1:0] mem [2**TID_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/rob_tid_alloc.sv
// Stamps AXI read requests with in-order tIDs, forwards them to tag compare, and keeps the tID->ARID map.
// Latency: AR accepted in cycle N is presented on req_* in cycle N+1.
// Backpressure: s_arready_o low while the output stage is held or MAX_OUTSTANDING reads are in flight.
module rob_tid_alloc
   import rob_tid_alloc_pkg::*;
#(
   parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
   parameter int ID_WIDTH        = AXI_ID_WIDTH,
   parameter int TID_WIDTH       = rob_tid_alloc_pkg::TID_WIDTH,
   parameter int MAX_OUTSTANDING = FIFO_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   input  logic [ID_WIDTH-1:0]   s_arid_i,
   input  logic [ADDR_WIDTH-1:0] s_araddr_i,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic [TID_WIDTH-1:0]  req_tid_o,
   output logic [ADDR_WIDTH-1:0] req_addr_o,
   input  logic                  retire_i,
   output logic [ID_WIDTH-1:0]   retire_rid_o,
   output logic [TID_WIDTH:0]    outstanding_o,
   output logic                  err_o
);

   localparam logic [TID_WIDTH:0]   MAX_CNT = (TID_WIDTH+1)'(MAX_OUTSTANDING);
   localparam logic [TID_WIDTH-1:0] TID_ONE = {{(TID_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [TID_WIDTH:0]   CNT_ONE = {{TID_WIDTH{1'b0}}, 1'b1};

   logic [0:0]            state;
   logic [TID_WIDTH-1:0]  next_tid;
   logic [TID_WIDTH-1:0]  ret_ptr;
   logic [TID_WIDTH:0]    outstanding;
   logic                  err;
   logic                  ar_fire;
   logic                  ret_ok;

   assign s_arready_o   = ((state == S_EMPTY) | req_ready_i) & (outstanding < MAX_CNT) & ~rst;
   assign ar_fire       = s_arvalid_i & s_arready_o;
   // A retire with nothing in flight is a ROB protocol violation: flag it, do not act on it.
   assign ret_ok        = retire_i & (outstanding != '0);
   assign req_valid_o   = (state == S_FULL);
   assign outstanding_o = outstanding;
   assign err_o         = err;

   rob_tid_alloc_tid_table #(
      .TID_WIDTH (TID_WIDTH),
      .ID_WIDTH  (ID_WIDTH)
   ) u_tid_table (
      .clk    (clk),
      .wr_en  (ar_fire),
      .wr_idx (next_tid),
      .wr_dat (s_arid_i),
      .rd_idx (ret_ptr),
      .rd_dat (retire_rid_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         next_tid    <= TID_ONE;
         ret_ptr     <= TID_ONE;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         if (ar_fire) begin
            next_tid <= next_tid + TID_ONE;
         end
         if (ret_ok) begin
            ret_ptr <= ret_ptr + TID_ONE;
         end
         if (retire_i && !ret_ok) begin
            err <= 1'b1;
         end
         if (ar_fire && !ret_ok) begin
            outstanding <= outstanding + CNT_ONE;
         end else if (!ar_fire && ret_ok) begin
            outstanding <= outstanding - CNT_ONE;
         end
      end
   end

   // Single-entry output stage; reloads back-to-back when drained and refilled in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_EMPTY;
         req_tid_o  <= '0;
         req_addr_o <= '0;
      end else if (ar_fire) begin
         state      <= S_FULL;
         req_tid_o  <= next_tid;
         req_addr_o <= s_araddr_i;
      end else if (req_ready_i) begin
         state      <= S_EMPTY;
      end
   end

endmodule

// File: tb/tb_rob_tid_alloc.sv
// Randomized + directed scoreboard bench for rob_tid_alloc (TID_WIDTH=3, MAX_OUTSTANDING=4).
module tb_rob_tid_alloc;

   localparam int AW  = 16;
   localparam int IW  = 4;
   localparam int TW  = 3;
   localparam int MAX = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_arvalid_i;
   logic          s_arready_o;
   logic [IW-1:0] s_arid_i;
   logic [AW-1:0] s_araddr_i;
   logic          req_valid_o;
   logic          req_ready_i;
   logic [TW-1:0] req_tid_o;
   logic [AW-1:0] req_addr_o;
   logic          retire_i;
   logic [IW-1:0] retire_rid_o;
   logic [TW:0]   outstanding_o;
   logic          err_o;

   rob_tid_alloc #(
      .ADDR_WIDTH      (AW),
      .ID_WIDTH        (IW),
      .TID_WIDTH       (TW),
      .MAX_OUTSTANDING (MAX)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_arvalid_i   (s_arvalid_i),
      .s_arready_o   (s_arready_o),
      .s_arid_i      (s_arid_i),
      .s_araddr_i    (s_araddr_i),
      .req_valid_o   (req_valid_o),
      .req_ready_i   (req_ready_i),
      .req_tid_o     (req_tid_o),
      .req_addr_o    (req_addr_o),
      .retire_i      (retire_i),
      .retire_rid_o  (retire_rid_o),
      .outstanding_o (outstanding_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tid;
      int addr;
   } req_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   armed = 1'b0;
   req_t exp_q[$];     // requests the DUT should be presenting, oldest first
   int   ids_q[$];     // ARIDs of in-flight tIDs, oldest first
   int   n_acc = 0;    // requests accepted since reset
   bit   stage_busy = 1'b0;
   bit   err_m = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the output stage presents against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            chk("req_valid", 32'(req_valid_o), 32'(exp_q.size() != 0));
            if (req_valid_o === 1'b1 && exp_q.size() != 0) begin
               chk("req_tid", 32'(req_tid_o), 32'(exp_q[0].tid));
               chk("req_addr", 32'(req_addr_o), 32'(exp_q[0].addr));
               if (req_ready_i === 1'b1) void'(exp_q.pop_front());
            end
         end
      end
   end

   // One clock of stimulus; checks credit/table/err outputs and updates the reference model.
   task automatic cycle(input bit arv, input int id, input int addr, input bit rdy,
                        input bit ret, input bit r);
      bit   fire;
      bit   pend;
      req_t it;
      s_arvalid_i = arv;
      s_arid_i    = IW'(id);
      s_araddr_i  = AW'(addr);
      req_ready_i = rdy;
      retire_i    = ret;
      rst         = r;
      pend        = 1'b0;
      @(negedge clk);
      chk("arready", 32'(s_arready_o),
          32'(!r && ids_q.size() < MAX && (!stage_busy || rdy)));
      chk("outstanding", 32'(outstanding_o), 32'(ids_q.size()));
      chk("err", 32'(err_o), 32'(err_m));
      if (ids_q.size() != 0) chk("retire_rid", 32'(retire_rid_o), 32'(ids_q[0]));
      fire = arv && (s_arready_o === 1'b1);
      if (r) begin
         ids_q.delete();
         n_acc      = 0;
         stage_busy = 1'b0;
         err_m      = 1'b0;
      end else begin
         if (ret) begin
            if (ids_q.size() == 0) err_m = 1'b1;
            else void'(ids_q.pop_front());
         end
         if (fire) begin
            n_acc++;
            it.tid  = n_acc % (1 << TW);
            it.addr = addr % (1 << AW);
            pend    = 1'b1;
            ids_q.push_back(id % (1 << IW));
         end
         stage_busy = fire ? 1'b1 : (rdy ? 1'b0 : stage_busy);
      end
      @(posedge clk);
      #1;
      if (r) exp_q.delete();
      if (pend) exp_q.push_back(it);
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 0, 0, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; s_arvalid_i = 1'b0; s_arid_i = '0; s_araddr_i = '0;
      req_ready_i = 1'b0; retire_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_arready", 32'(s_arready_o), 32'd0);
      chk("rst_valid", 32'(req_valid_o), 32'd0);
      chk("rst_tid", 32'(req_tid_o), 32'd0);
      chk("rst_addr", 32'(req_addr_o), 32'd0);
      chk("rst_outstanding", 32'(outstanding_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      @(posedge clk);
      #1;
      armed = 1'b1;

      // single request, then retire
      cycle(1'b1, 5, 'h40, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // back-to-back burst, then in-order retires
      for (int i = 1; i <= 4; i++) cycle(1'b1, i, 'h100 + i, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // credit limit: fifth request stalls until a retire frees a slot
      for (int i = 0; i < 6; i++) cycle(1'b1, 8 + i, 'h200 + i, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 14, 'h206, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 14, 'h206, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

      // output stage held by req_ready_i low
      cycle(1'b1, 3, 'h3c3c, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 7, 'h7777, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

      // tID wrap with simultaneous fire + retire, then retire on empty
      for (int i = 0; i < 10; i++) cycle(1'b1, i, 'h500 + i, 1'b1, ids_q.size() != 0, 1'b0);
      while (ids_q.size() != 0) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // reset mid-burst
      for (int i = 0; i < 3; i++) cycle(1'b1, 9, 'h900 + i, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 2, 'hbeef, 1'b1, 1'b0, 1'b0);
      idle(1'b1);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
      end
      for (int i = 0; i < 3; i++) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
